unified_mem_arb: RTL and testbench

Parametrised single-array, byte-addressed unified memory shared by the instruction-fetch and data (load/store) paths of the single-cycle/pipelined RISC-V core. Two request ports, one per path, contend for one physical array port per cycle under a fair arbiter. Every access returns a registered response one cycle after grant. Loads support LW/LH/LHU/LB/LBU with correct sign extension; stores support SW/SH/SB. Data addresses are relocated by a fixed base offset; misaligned data accesses are flagged, not executed.

---
 rtl/core_mem_pkg.sv | 69 ++++++
 rtl/unified_mem_arb_if.sv | 31 +++
 rtl/mem_rr_arb2.sv | 47 ++++
 rtl/unified_mem_arb.sv | 127 ++++++++++++
 tb/tb_unified_mem_arb.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/core_mem_pkg.sv
// Shared types and helpers for the unified instruction/data memory:
// access-size encodings, port identifiers, load extension and store lane helpers.
package core_mem_pkg;

   typedef enum logic [1:0] {
      MEM_WORD    = 2'b00,
      MEM_HALF    = 2'b01,
      MEM_BYTE    = 2'b10,
      MEM_ILLEGAL = 2'b11
   } mem_size_e;

   typedef enum logic {
      PORT_IF = 1'b0,
      PORT_D  = 1'b1
   } port_e;

   // True when the access cannot be executed; the illegal size encoding
   // is folded in so callers get a single error condition.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr);
      logic bad;
      case (size)
         MEM_WORD: bad = (addr != 2'b00);
         MEM_HALF: bad = addr[0];
         MEM_BYTE: bad = 1'b0;
         default:  bad = 1'b1;
      endcase
      return bad;
   endfunction

   // Pick the addressed lane out of an aligned word and sign/zero extend it.
   function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                               input logic sgn, input logic [1:0] byte_off);
      logic [31:0] sh;
      logic [31:0] res;
      sh = word >> {byte_off, 3'b000};
      case (size)
         MEM_WORD: res = word;
         MEM_HALF: res = {{16{sgn & sh[15]}}, sh[15:0]};
         MEM_BYTE: res = {{24{sgn & sh[7]}}, sh[7:0]};
         default:  res = 32'h0000_0000;
      endcase
      return res;
   endfunction

   // Byte enables within the aligned word for a store.
   function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] byte_off);
      logic [3:0] be;
      case (size)
         MEM_WORD: be = 4'b1111;
         MEM_HALF: be = 4'b0011 << byte_off;
         MEM_BYTE: be = 4'b0001 << byte_off;
         default:  be = 4'b0000;
      endcase
      return be;
   endfunction

   // Replicate the low store bytes onto every lane so the enables pick them.
   function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
      logic [31:0] lanes;
      case (size)
         MEM_WORD: lanes = wdata;
         MEM_HALF: lanes = {2{wdata[15:0]}};
         MEM_BYTE: lanes = {4{wdata[7:0]}};
         default:  lanes = 32'h0000_0000;
      endcase
      return lanes;
   endfunction

endpackage

// File: rtl/unified_mem_arb_if.sv
// Request/response bundle for the fetch and data ports of the unified memory.
interface unified_mem_arb_if #(
   parameter int AW = 10
) ();
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_gnt;
   logic          if_valid;
   logic [31:0]   if_rdata;

   logic          d_req;
   logic          d_we;
   logic [1:0]    d_size;
   logic          d_signed;
   logic [AW-1:0] d_addr;
   logic [31:0]   d_wdata;
   logic          d_gnt;
   logic          d_valid;
   logic [31:0]   d_rdata;
   logic          d_err;

   modport master (
      output if_req, if_addr, d_req, d_we, d_size, d_signed, d_addr, d_wdata,
      input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata, d_err
   );

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_size, d_signed, d_addr, d_wdata,
      output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata, d_err
   );
endinterface

// File: rtl/mem_rr_arb2.sv
// Two-requester round-robin arbiter. last_q remembers the winner of the most
// recent conflict; the other port wins the next one.
module mem_rr_arb2
   import core_mem_pkg::*;
(
   input  logic sclk,
   input  logic rst_n,
   input  logic if_req_i,
   input  logic d_req_i,
   output logic if_gnt_o,
   output logic d_gnt_o
);
   port_e last_q;
   port_e last_d;

   // State register: fetch counts as last winner so data takes the first conflict.
   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= PORT_IF;
      end else begin
         last_q <= last_d;
      end
   end

   // Next state: only a conflict moves the pointer.
   always_comb begin
      last_d = last_q;
      if (if_req_i && d_req_i) begin
         last_d = (last_q == PORT_IF) ? PORT_D : PORT_IF;
      end else begin
         last_d = last_q;
      end
   end

   // Grant outputs: a lone requester always wins.
   always_comb begin
      if_gnt_o = 1'b0;
      d_gnt_o  = 1'b0;
      if (if_req_i && d_req_i) begin
         d_gnt_o  = (last_q == PORT_IF);
         if_gnt_o = (last_q == PORT_D);
      end else begin
         if_gnt_o = if_req_i;
         d_gnt_o  = d_req_i;
      end
   end
endmodule

// File: rtl/unified_mem_arb.sv
// Byte-addressed memory shared by instruction fetch and load/store. One array
// access per cycle; each accepted request gets a registered response next cycle.
module unified_mem_arb
   import core_mem_pkg::*;
#(
   parameter int MEM_BYTES = 1024,
   parameter int AW        = $clog2(MEM_BYTES),
   parameter int DATA_BASE = 100
) (
   input logic              sclk,
   input logic              rst_n,
   unified_mem_arb_if.slave bus
);
   localparam logic [AW-1:0] DBASE = AW'(DATA_BASE);

   // Array contents are deliberately not reset.
   logic [7:0]    mem_q [MEM_BYTES];

   logic          if_gnt_s;
   logic          d_gnt_s;
   logic [AW-1:0] d_pa_s;
   logic          d_bad_s;
   logic [AW-1:0] rd_wa_s;
   logic [31:0]   rd_word_s;
   logic          mem_we_s;
   logic [3:0]    be_s;
   logic [31:0]   lanes_s;
   logic          unused_addr_s;

   logic          if_valid_q, if_valid_d;
   logic [31:0]   if_rdata_q, if_rdata_d;
   logic          d_valid_q,  d_valid_d;
   logic [31:0]   d_rdata_q,  d_rdata_d;
   logic          d_err_q,    d_err_d;

   mem_rr_arb2 u_arb (
      .sclk     (sclk),
      .rst_n    (rst_n),
      .if_req_i (bus.if_req),
      .d_req_i  (bus.d_req),
      .if_gnt_o (if_gnt_s),
      .d_gnt_o  (d_gnt_s)
   );

   // Data addresses are relocated and wrap naturally at the array size.
   assign d_pa_s        = bus.d_addr + DBASE;
   assign d_bad_s       = misaligned(bus.d_size, d_pa_s[1:0]);
   assign unused_addr_s = ^bus.if_addr[1:0];
   assign be_s          = store_be(bus.d_size, d_pa_s[1:0]);
   assign lanes_s       = store_lanes(bus.d_size, bus.d_wdata);
   assign mem_we_s      = d_gnt_s & bus.d_we & ~d_bad_s;

   // Single read port: word address of whichever port holds the grant.
   always_comb begin
      rd_wa_s = {AW{1'b0}};
      if (d_gnt_s) begin
         rd_wa_s = {d_pa_s[AW-1:2], 2'b00};
      end else begin
         rd_wa_s = {bus.if_addr[AW-1:2], 2'b00};
      end
   end

   assign rd_word_s = {mem_q[{rd_wa_s[AW-1:2], 2'b11}], mem_q[{rd_wa_s[AW-1:2], 2'b10}],
                       mem_q[{rd_wa_s[AW-1:2], 2'b01}], mem_q[{rd_wa_s[AW-1:2], 2'b00}]};

   // Store path: write only the enabled bytes at the grant edge.
   always_ff @(posedge sclk) begin
      if (mem_we_s) begin
         for (int k = 0; k < 4; k++) begin
            if (be_s[k]) begin
               mem_q[{d_pa_s[AW-1:2], 2'(k)}] <= lanes_s[8*k +: 8];
            end
         end
      end
   end

   // Next response: data holds while idle, valid pulses on an accept.
   always_comb begin
      if_valid_d = 1'b0;
      if_rdata_d = if_rdata_q;
      d_valid_d  = 1'b0;
      d_rdata_d  = d_rdata_q;
      d_err_d    = d_err_q;
      if (if_gnt_s) begin
         if_valid_d = 1'b1;
         if_rdata_d = rd_word_s;
      end else begin
         if_valid_d = 1'b0;
      end
      if (d_gnt_s) begin
         d_valid_d = 1'b1;
         d_err_d   = d_bad_s;
         if (d_bad_s || bus.d_we) begin
            d_rdata_d = 32'h0000_0000;
         end else begin
            d_rdata_d = load_extend(rd_word_s, bus.d_size, bus.d_signed, d_pa_s[1:0]);
         end
      end else begin
         d_valid_d = 1'b0;
      end
   end

   // Response registers; reset drops any pending response.
   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         if_valid_q <= 1'b0;
         if_rdata_q <= 32'h0000_0000;
         d_valid_q  <= 1'b0;
         d_rdata_q  <= 32'h0000_0000;
         d_err_q    <= 1'b0;
      end else begin
         if_valid_q <= if_valid_d;
         if_rdata_q <= if_rdata_d;
         d_valid_q  <= d_valid_d;
         d_rdata_q  <= d_rdata_d;
         d_err_q    <= d_err_d;
      end
   end

   assign bus.if_gnt   = if_gnt_s;
   assign bus.d_gnt    = d_gnt_s;
   assign bus.if_valid = if_valid_q;
   assign bus.if_rdata = if_rdata_q;
   assign bus.d_valid  = d_valid_q;
   assign bus.d_rdata  = d_rdata_q;
   assign bus.d_err    = d_err_q;
endmodule

// File: tb/tb_unified_mem_arb.sv
// Directed bench for unified_mem_arb: loads/stores with extension, misalignment,
// fetch, address wrap, round-robin conflicts and reset during a pending response.
module tb_unified_mem_arb;
   import core_mem_pkg::*;

   localparam int AW = 10;

   logic sclk;
   logic rst_n;
   int   checks;
   int   failures;

   unified_mem_arb_if #(.AW(AW)) bus ();

   unified_mem_arb #(.MEM_BYTES(1024), .AW(AW), .DATA_BASE(100)) dut (
      .sclk  (sclk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running clock.
   initial begin
      sclk = 1'b0;
      forever #5 sclk = ~sclk;
   end

   // Compare one observed value with its expected value.
   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One data-port access issued at a negedge; ends at the response negedge.
   task automatic d_op(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                       input logic [AW-1:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err);
      bus.d_req    = 1'b1;
      bus.d_we     = we;
      bus.d_size   = size;
      bus.d_signed = sgn;
      bus.d_addr   = addr;
      bus.d_wdata  = wdata;
      #1;
      check_eq({tag, "_gnt"}, 32'(bus.d_gnt), 32'd1);
      @(posedge sclk);
      #1;
      bus.d_req = 1'b0;
      @(negedge sclk);
      check_eq({tag, "_valid"}, 32'(bus.d_valid), 32'd1);
      check_eq({tag, "_rdata"}, bus.d_rdata, exp_rdata);
      check_eq({tag, "_err"}, 32'(bus.d_err), 32'(exp_err));
   endtask

   // One fetch issued at a negedge; ends at the response negedge.
   task automatic if_op(input string tag, input logic [AW-1:0] addr, input logic [31:0] exp_rdata);
      bus.if_req  = 1'b1;
      bus.if_addr = addr;
      #1;
      check_eq({tag, "_gnt"}, 32'(bus.if_gnt), 32'd1);
      @(posedge sclk);
      #1;
      bus.if_req = 1'b0;
      @(negedge sclk);
      check_eq({tag, "_valid"}, 32'(bus.if_valid), 32'd1);
      check_eq({tag, "_rdata"}, bus.if_rdata, exp_rdata);
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      rst_n        = 1'b0;
      bus.if_req   = 1'b0;
      bus.if_addr  = '0;
      bus.d_req    = 1'b0;
      bus.d_we     = 1'b0;
      bus.d_size   = 2'b00;
      bus.d_signed = 1'b0;
      bus.d_addr   = '0;
      bus.d_wdata  = 32'h0;

      repeat (2) @(negedge sclk);
      check_eq("rst_if_valid", 32'(bus.if_valid), 32'd0);
      check_eq("rst_d_valid", 32'(bus.d_valid), 32'd0);
      check_eq("rst_d_err", 32'(bus.d_err), 32'd0);
      check_eq("rst_if_rdata", bus.if_rdata, 32'h0);
      check_eq("rst_d_rdata", bus.d_rdata, 32'h0);
      rst_n = 1'b1;
      @(negedge sclk);

      // Preload through the data port, then read back.
      d_op("sw0", 1'b1, MEM_WORD, 1'b0, 10'd0, 32'h0000_0011, 32'h0, 1'b0);
      d_op("lw0", 1'b0, MEM_WORD, 1'b0, 10'd0, 32'h0, 32'h0000_0011, 1'b0);
      @(negedge sclk);
      check_eq("d_valid_pulse", 32'(bus.d_valid), 32'd0);

      // Sign / zero extension on bytes 104..105 = F0 80.
      d_op("sh4",  1'b1, MEM_HALF, 1'b0, 10'd4, 32'h0000_80F0, 32'h0, 1'b0);
      d_op("lb4",  1'b0, MEM_BYTE, 1'b1, 10'd4, 32'h0, 32'hFFFF_FFF0, 1'b0);
      d_op("lbu4", 1'b0, MEM_BYTE, 1'b0, 10'd4, 32'h0, 32'h0000_00F0, 1'b0);
      d_op("lh4",  1'b0, MEM_HALF, 1'b1, 10'd4, 32'h0, 32'hFFFF_80F0, 1'b0);
      d_op("lhu4", 1'b0, MEM_HALF, 1'b0, 10'd4, 32'h0, 32'h0000_80F0, 1'b0);
      d_op("lb5",  1'b0, MEM_BYTE, 1'b1, 10'd5, 32'h0, 32'hFFFF_FF80, 1'b0);

      // Partial stores leave the other bytes untouched.
      d_op("sw8",  1'b1, MEM_WORD, 1'b0, 10'd8,  32'h1122_3344, 32'h0, 1'b0);
      d_op("sh8",  1'b1, MEM_HALF, 1'b0, 10'd8,  32'hAABB_CCDD, 32'h0, 1'b0);
      d_op("lw8a", 1'b0, MEM_WORD, 1'b0, 10'd8,  32'h0, 32'h1122_CCDD, 1'b0);
      d_op("sb11", 1'b1, MEM_BYTE, 1'b0, 10'd11, 32'h0000_00EE, 32'h0, 1'b0);
      d_op("lw8b", 1'b0, MEM_WORD, 1'b0, 10'd8,  32'h0, 32'hEE22_CCDD, 1'b0);

      // Misaligned and illegal accesses are flagged and not executed.
      d_op("lw1",  1'b0, MEM_WORD,    1'b0, 10'd1, 32'h0, 32'h0, 1'b1);
      d_op("sw1",  1'b1, MEM_WORD,    1'b0, 10'd1, 32'hDEAD_BEEF, 32'h0, 1'b1);
      d_op("lw0b", 1'b0, MEM_WORD,    1'b0, 10'd0, 32'h0, 32'h0000_0011, 1'b0);
      d_op("lh1",  1'b0, MEM_HALF,    1'b1, 10'd1, 32'h0, 32'h0, 1'b1);
      d_op("ill",  1'b0, MEM_ILLEGAL, 1'b0, 10'd0, 32'h0, 32'h0, 1'b1);
      d_op("lh2",  1'b0, MEM_HALF,    1'b1, 10'd2, 32'h0, 32'h0, 1'b0);

      // Relocation wraps: d_addr 924 + 100 lands on byte 0, seen by fetch.
      d_op("sw924", 1'b1, MEM_WORD, 1'b0, 10'd924, 32'hCAFE_F00D, 32'h0, 1'b0);
      if_op("if0",   10'd0,   32'hCAFE_F00D);
      if_op("if101", 10'd101, 32'h0000_0011);
      if_op("if108", 10'd108, 32'hEE22_CCDD);

      // Both ports held: grants alternate D, IF, D, IF.
      bus.if_req   = 1'b1;
      bus.if_addr  = 10'd100;
      bus.d_req    = 1'b1;
      bus.d_we     = 1'b0;
      bus.d_size   = MEM_WORD;
      bus.d_signed = 1'b0;
      bus.d_addr   = 10'd8;
      for (int i = 0; i < 4; i++) begin
         #1;
         check_eq($sformatf("rr%0d_d_gnt", i), 32'(bus.d_gnt), 32'((i % 2) == 0));
         check_eq($sformatf("rr%0d_if_gnt", i), 32'(bus.if_gnt), 32'((i % 2) == 1));
         @(posedge sclk);
         @(negedge sclk);
         check_eq($sformatf("rr%0d_d_valid", i), 32'(bus.d_valid), 32'((i % 2) == 0));
         check_eq($sformatf("rr%0d_if_valid", i), 32'(bus.if_valid), 32'((i % 2) == 1));
         if ((i % 2) == 0) begin
            check_eq($sformatf("rr%0d_d_rdata", i), bus.d_rdata, 32'hEE22_CCDD);
         end else begin
            check_eq($sformatf("rr%0d_if_rdata", i), bus.if_rdata, 32'h0000_0011);
         end
      end
      bus.if_req = 1'b0;
      bus.d_req  = 1'b0;
      @(negedge sclk);

      // Leave an error response registered, then reset under a pending fetch.
      d_op("lw1b", 1'b0, MEM_WORD, 1'b0, 10'd1, 32'h0, 32'h0, 1'b1);
      bus.if_req  = 1'b1;
      bus.if_addr = 10'd108;
      #1;
      check_eq("rst_fetch_gnt", 32'(bus.if_gnt), 32'd1);
      @(posedge sclk);
      #1;
      rst_n      = 1'b0;
      bus.if_req = 1'b0;
      @(negedge sclk);
      check_eq("mid_rst_if_valid", 32'(bus.if_valid), 32'd0);
      check_eq("mid_rst_d_valid", 32'(bus.d_valid), 32'd0);
      check_eq("mid_rst_d_err", 32'(bus.d_err), 32'd0);
      check_eq("mid_rst_if_rdata", bus.if_rdata, 32'h0);
      check_eq("mid_rst_d_rdata", bus.d_rdata, 32'h0);
      @(negedge sclk);
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge sclk);
         check_eq($sformatf("post_rst%0d_if_valid", i), 32'(bus.if_valid), 32'd0);
      end

      // First post-reset conflict goes to data; array contents survived.
      bus.if_req   = 1'b1;
      bus.if_addr  = 10'd100;
      bus.d_req    = 1'b1;
      bus.d_we     = 1'b0;
      bus.d_size   = MEM_WORD;
      bus.d_addr   = 10'd8;
      #1;
      check_eq("post_rst_d_gnt", 32'(bus.d_gnt), 32'd1);
      check_eq("post_rst_if_gnt", 32'(bus.if_gnt), 32'd0);
      @(posedge sclk);
      #1;
      bus.if_req = 1'b0;
      bus.d_req  = 1'b0;
      @(negedge sclk);
      check_eq("post_rst_d_valid", 32'(bus.d_valid), 32'd1);
      check_eq("post_rst_if_valid", 32'(bus.if_valid), 32'd0);
      check_eq("post_rst_d_rdata", bus.d_rdata, 32'hEE22_CCDD);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
